// File: rtl/serializador_if.sv
// serializador_if -- handshake/data bundle for the serializador.
//   data_in : parallel word offered by the producer
//   load    : request to serialize data_in
//   x       : serial bit stream, MSB first
//   valid   : x carries a word (or parity) bit
//   busy    : a word is in flight
//   done    : one-cycle pulse after the final bit of a word
// master = producer/observer side, slave = the serializador.
interface serializador_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] data_in;
  logic             load;
  logic             x;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (output data_in, load, input x, valid, busy, done);
  modport slave  (input data_in, load, output x, valid, busy, done);
endinterface

// File: rtl/serializador.sv
// serializador -- parallel-to-serial converter, MSB first, with back-to-back
// word support (a load in the last-bit cycle starts the next word with no gap).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serializador_if.slave (data_in, load in; x, valid, busy, done out)
// Parameter WIDTH: data bits per word (2..32).
// Optional feature: define SERIALIZADOR_PARITY_EN to append one even-parity
// bit (XOR of the captured word) after bit 0.
module serializador #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serializador_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

`ifdef SERIALIZADOR_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  logic             tail;    // cycle in which the word's final bit is on x
  logic             accept;
`ifdef SERIALIZADOR_PARITY_EN
  logic             par_q;
  logic             last_data;

  assign last_data = (state == SHIFT) && (cnt == '0);
  assign tail      = (state == PARITY);
`else
  assign tail      = (state == SHIFT) && (cnt == '0);
`endif

  // Loads are only honoured when idle or while the final bit is presented.
  assign accept = bus.load && ((state == IDLE) || tail);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIALIZADOR_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      // done is a pure delayed copy of tail: exactly one cycle per word.
      done_q <= tail;
      if (accept) begin
        state   <= SHIFT;
        sreg    <= bus.data_in;
        cnt     <= CW'(WIDTH - 1);
        valid_q <= 1'b1;
        busy_q  <= 1'b1;
`ifdef SERIALIZADOR_PARITY_EN
        par_q   <= ^bus.data_in;
`endif
      end else if (tail) begin
        state   <= IDLE;
        sreg    <= '0;   // keeps x low while idle
        cnt     <= '0;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
`ifdef SERIALIZADOR_PARITY_EN
      end else if (last_data) begin
        // Park the parity bit in the MSB so x stays a plain register tap.
        state <= PARITY;
        sreg  <= {par_q, {(WIDTH-1){1'b0}}};
`endif
      end else if (state == SHIFT) begin
        // cnt is non-zero here, so it never wraps.
        sreg <= {sreg[WIDTH-2:0], 1'b0};
        cnt  <= cnt - 1'b1;
      end
    end
  end

  assign bus.x     = sreg[WIDTH-1];
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule
